// File: rtl/letc_core_pipe_ctrl_if.sv
// Bundle of the pipeline-control nets between letc_core_pipe_ctrl and the
// rest of letc_core_top. The controller is the slave; the stage/MSS side that
// produces the requests and acks is the master.
//
// Handshake rules:
//   redirect: the requester raises redirect_valid with stable
//     redirect_stage_idx/redirect_pc and holds them until the cycle in which
//     pc_load_en is high (acceptance is combinational in that same cycle).
//   fence_req, imss_flush_ack, dmss_flush_ack: single-cycle pulses.
//   imss_flush_req, dmss_flush_req: levels, each dropping the cycle after
//     its own ack.
interface letc_core_pipe_ctrl_if #(
    parameter int NUM_STAGES = 7
);
    logic [NUM_STAGES-1:0] stage_ready;
    logic                  redirect_valid;
    logic [2:0]            redirect_stage_idx;
    logic [31:0]           redirect_pc;
    logic                  fence_req;
    logic [31:0]           fence_next_pc;
    logic                  dmss_idle;
    logic                  imss_flush_ack;
    logic                  dmss_flush_ack;
    logic [NUM_STAGES-1:0] stage_stall;
    logic [NUM_STAGES-1:0] stage_flush;
    logic                  pc_load_en;
    logic [31:0]           pc_load_val;
    logic                  imss_flush_req;
    logic                  dmss_flush_req;
    logic                  busy;

    modport master (
        output stage_ready, redirect_valid, redirect_stage_idx, redirect_pc,
               fence_req, fence_next_pc, dmss_idle, imss_flush_ack, dmss_flush_ack,
        input  stage_stall, stage_flush, pc_load_en, pc_load_val,
               imss_flush_req, dmss_flush_req, busy
    );

    modport slave (
        input  stage_ready, redirect_valid, redirect_stage_idx, redirect_pc,
               fence_req, fence_next_pc, dmss_idle, imss_flush_ack, dmss_flush_ack,
        output stage_stall, stage_flush, pc_load_en, pc_load_val,
               imss_flush_req, dmss_flush_req, busy
    );
endinterface

// File: rtl/letc_core_pipe_ctrl.sv
// Pipeline sequencing controller for the seven-stage LETC core.
// Converts per-stage ready into stall/flush vectors, arbitrates branch/trap
// redirects onto the fetch PC port and sequences fence.i / sfence.vma
// (drain, IMSS+DMSS flush handshake, resume). State is exported on
// state_dbg_o for observation.
module letc_core_pipe_ctrl #(
    parameter int NUM_STAGES = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    letc_core_pipe_ctrl_if.slave ctrl_if,
    output logic [1:0]           state_dbg_o
);
    localparam int W_STAGE_IDX = NUM_STAGES - 1;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_RESUME = 2'd3;

    localparam logic [NUM_STAGES-1:0] ALL_STAGES  = '1;
    // Fence flushes everything younger than W; the fence itself retires.
    localparam logic [NUM_STAGES-1:0] FENCE_FLUSH = ALL_STAGES >> 1;

    logic [1:0]            state_q, state_d;
    logic [31:0]           fence_pc_q, fence_pc_d;
    logic                  imss_req_q, imss_req_d;
    logic                  dmss_req_q, dmss_req_d;
    logic                  imss_done_q, imss_done_d;
    logic                  dmss_done_q, dmss_done_d;

    logic [NUM_STAGES-1:0] not_ready;
    logic [NUM_STAGES-1:0] run_stall;
    logic [NUM_STAGES-1:0] redir_mask;
    logic                  idx_valid;
    logic                  redir_ok;
    logic                  fence_ok;
    logic                  take_redir;
    logic                  take_fence;

    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic                  pc_en_c;
    logic [31:0]           pc_val_c;

    assign not_ready = ~ctrl_if.stage_ready;

    // Backpressure: a not-ready stage freezes itself and every younger stage.
    always_comb begin
        run_stall = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            run_stall[i] = |(not_ready >> i);
        end
    end

    // Redirect/fence arbitration; a W redirect beats a fence in the same cycle.
    always_comb begin
        redir_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            redir_mask[i] = (i < int'(ctrl_if.redirect_stage_idx));
        end
        idx_valid  = int'(ctrl_if.redirect_stage_idx) < NUM_STAGES;
        redir_ok   = ctrl_if.redirect_valid && idx_valid
                     && !run_stall[ctrl_if.redirect_stage_idx];
        fence_ok   = ctrl_if.fence_req && !run_stall[W_STAGE_IDX];
        take_redir = redir_ok
                     && (int'(ctrl_if.redirect_stage_idx) == W_STAGE_IDX || !fence_ok);
        take_fence = fence_ok && !take_redir;
    end

    // Flush request levels and ack latches; both requests rise on DRAIN->FLUSH.
    always_comb begin
        imss_done_d = imss_done_q | (ctrl_if.imss_flush_ack & imss_req_q);
        dmss_done_d = dmss_done_q | (ctrl_if.dmss_flush_ack & dmss_req_q);
        imss_req_d  = imss_req_q & ~ctrl_if.imss_flush_ack;
        dmss_req_d  = dmss_req_q & ~ctrl_if.dmss_flush_ack;
        if (state_q == ST_DRAIN && ctrl_if.dmss_idle) begin
            imss_req_d  = 1'b1;
            dmss_req_d  = 1'b1;
            imss_done_d = 1'b0;
            dmss_done_d = 1'b0;
        end
        if (state_q == ST_RESUME) begin
            imss_done_d = 1'b0;
            dmss_done_d = 1'b0;
        end
    end

    // Next state and the stall/flush/PC-load outputs for each state.
    always_comb begin
        state_d    = state_q;
        fence_pc_d = fence_pc_q;
        stall_c    = '0;
        flush_c    = '0;
        pc_en_c    = 1'b0;
        pc_val_c   = '0;
        case (state_q)
            ST_RUN: begin
                if (take_redir) begin
                    flush_c  = redir_mask;
                    pc_en_c  = 1'b1;
                    pc_val_c = ctrl_if.redirect_pc;
                end else if (take_fence) begin
                    flush_c    = FENCE_FLUSH;
                    fence_pc_d = ctrl_if.fence_next_pc;
                    state_d    = ST_DRAIN;
                end
                // A flushed stage must not also hold.
                stall_c = run_stall & ~flush_c;
            end
            ST_DRAIN: begin
                stall_c = '1;
                flush_c = '1;
                if (ctrl_if.dmss_idle) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                stall_c = '1;
                flush_c = '1;
                if (imss_done_d && dmss_done_d) begin
                    state_d = ST_RESUME;
                end
            end
            ST_RESUME: begin
                flush_c  = '1;
                pc_en_c  = 1'b1;
                pc_val_c = fence_pc_q;
                state_d  = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Reset forces a clean, flushed, non-loading pipeline.
        if (!rst_n) begin
            stall_c  = '0;
            flush_c  = '1;
            pc_en_c  = 1'b0;
            pc_val_c = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            fence_pc_q  <= '0;
            imss_req_q  <= 1'b0;
            dmss_req_q  <= 1'b0;
            imss_done_q <= 1'b0;
            dmss_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fence_pc_q  <= fence_pc_d;
            imss_req_q  <= imss_req_d;
            dmss_req_q  <= dmss_req_d;
            imss_done_q <= imss_done_d;
            dmss_done_q <= dmss_done_d;
        end
    end

    assign ctrl_if.stage_stall    = stall_c;
    assign ctrl_if.stage_flush    = flush_c;
    assign ctrl_if.pc_load_en     = pc_en_c;
    assign ctrl_if.pc_load_val    = pc_val_c;
    assign ctrl_if.imss_flush_req = rst_n & imss_req_q;
    assign ctrl_if.dmss_flush_req = rst_n & dmss_req_q;
    assign ctrl_if.busy           = rst_n && (state_q != ST_RUN);
    assign state_dbg_o            = state_q;

    // Redirects and fences can only be issued while the pipeline runs.
    no_req_outside_run: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != ST_RUN) |-> !(ctrl_if.redirect_valid || ctrl_if.fence_req));
endmodule

// File: tb/tb_letc_core_pipe_ctrl.sv
// Testbench for letc_core_pipe_ctrl: fixed vector table, hand-written fence,
// collision and reset sequences, then random traffic against a reference model.
module tb_letc_core_pipe_ctrl;
    localparam int N = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [6:0]  ready;
        logic        rv;
        logic [2:0]  idx;
        logic [31:0] pc;
        logic [6:0]  e_stall;
        logic [6:0]  e_flush;
        logic        e_en;
    } vec_t;
    vec_t vecs[13];

    // reference model state
    bit          m_drain, m_flush, m_resume, m_ireq, m_dreq, m_run;
    logic [31:0] m_pc;
    logic [6:0]  e_stall, e_flush;
    logic        e_en, e_ireq, e_dreq, e_busy, chk_val, fence_ok, take_r, take_f;
    logic [31:0] e_val;
    int          idx;

    letc_core_pipe_ctrl_if #(.NUM_STAGES(N)) bus ();

    letc_core_pipe_ctrl #(.NUM_STAGES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_if     (bus),
        .state_dbg_o (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.stage_ready        = '1;
        bus.redirect_valid     = 1'b0;
        bus.redirect_stage_idx = 3'd0;
        bus.redirect_pc        = 32'h0;
        bus.fence_req          = 1'b0;
        bus.fence_next_pc      = 32'h0;
        bus.dmss_idle          = 1'b1;
        bus.imss_flush_ack     = 1'b0;
        bus.dmss_flush_ack     = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [6:0] es, input logic [6:0] ef,
                              input logic en, input logic [31:0] val, input logic cv,
                              input logic ir, input logic dr, input logic bz);
        #2;
        check({tag, ".stall"}, 32'(bus.stage_stall), 32'(es));
        check({tag, ".flush"}, 32'(bus.stage_flush), 32'(ef));
        check({tag, ".pc_en"}, 32'(bus.pc_load_en), 32'(en));
        if (cv) check({tag, ".pc_val"}, bus.pc_load_val, val);
        check({tag, ".ireq"}, 32'(bus.imss_flush_req), 32'(ir));
        check({tag, ".dreq"}, 32'(bus.dmss_flush_req), 32'(dr));
        check({tag, ".busy"}, 32'(bus.busy), 32'(bz));
    endtask

    // Issue a fence in RUN, let DRAIN exit at once; returns in the first FLUSH cycle.
    task automatic fence_to_flush(input string tag, input logic [31:0] pc);
        set_idle();
        bus.fence_req     = 1'b1;
        bus.fence_next_pc = pc;
        check_outs({tag, ".req"}, 7'h00, 7'b0111111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_idle();
        check_outs({tag, ".drain"}, 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        set_idle();
    endtask

    initial begin
        vecs[0]  = '{7'b1111111, 1'b0, 3'd0, 32'h0000_0000, 7'b0000000, 7'b0000000, 1'b0};
        vecs[1]  = '{7'b1101111, 1'b0, 3'd0, 32'h0000_0000, 7'b0011111, 7'b0000000, 1'b0};
        vecs[2]  = '{7'b1111111, 1'b1, 3'd3, 32'h8000_0100, 7'b0000000, 7'b0000111, 1'b1};
        vecs[3]  = '{7'b1101111, 1'b1, 3'd3, 32'h8000_0100, 7'b0011111, 7'b0000000, 1'b0};
        vecs[4]  = '{7'b1111110, 1'b0, 3'd0, 32'h0000_0000, 7'b0000001, 7'b0000000, 1'b0};
        vecs[5]  = '{7'b0000000, 1'b0, 3'd0, 32'h0000_0000, 7'b1111111, 7'b0000000, 1'b0};
        vecs[6]  = '{7'b1111111, 1'b1, 3'd6, 32'h0000_0040, 7'b0000000, 7'b0111111, 1'b1};
        vecs[7]  = '{7'b1111111, 1'b1, 3'd0, 32'h0000_1234, 7'b0000000, 7'b0000000, 1'b1};
        vecs[8]  = '{7'b1111011, 1'b1, 3'd6, 32'hcafe_0000, 7'b0000000, 7'b0111111, 1'b1};
        vecs[9]  = '{7'b1111101, 1'b1, 3'd2, 32'h0000_0800, 7'b0000000, 7'b0000011, 1'b1};
        vecs[10] = '{7'b0111111, 1'b1, 3'd4, 32'h0000_0900, 7'b1111111, 7'b0000000, 1'b0};
        vecs[11] = '{7'b1110111, 1'b1, 3'd3, 32'h0000_0a00, 7'b0001111, 7'b0000000, 1'b0};
        vecs[12] = '{7'b1110111, 1'b1, 3'd5, 32'h0000_0b00, 7'b0000000, 7'b0011111, 1'b1};

        // reset values, with inputs that would otherwise stall and redirect
        set_idle();
        rst_n = 1'b0;
        bus.stage_ready        = '0;
        bus.redirect_valid     = 1'b1;
        bus.redirect_stage_idx = 3'd3;
        bus.redirect_pc        = 32'h1111_2222;
        tick();
        check_outs("reset", 7'h00, 7'h7f, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        set_idle();
        tick();

        // combinational vector table in RUN
        for (int v = 0; v < 13; v++) begin
            set_idle();
            bus.stage_ready        = vecs[v].ready;
            bus.redirect_valid     = vecs[v].rv;
            bus.redirect_stage_idx = vecs[v].idx;
            bus.redirect_pc        = vecs[v].pc;
            check_outs($sformatf("vec%0d", v), vecs[v].e_stall, vecs[v].e_flush,
                       vecs[v].e_en, vecs[v].pc, vecs[v].e_en, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // stalled branch held until M1 becomes ready
        for (int k = 0; k < 3; k++) begin
            set_idle();
            bus.stage_ready        = (k < 2) ? 7'b1101111 : 7'b1111111;
            bus.redirect_valid     = 1'b1;
            bus.redirect_stage_idx = 3'd3;
            bus.redirect_pc        = 32'h8000_0100;
            if (k < 2)
                check_outs("stalled_br", 7'b0011111, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                check_outs("released_br", 7'h00, 7'b0000111, 1'b1, 32'h8000_0100, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // fence with dmss_idle low for 3 cycles and dmss ack 2 cycles before imss ack
        set_idle();
        bus.fence_req     = 1'b1;
        bus.fence_next_pc = 32'h8000_0204;
        bus.dmss_idle     = 1'b0;
        check_outs("stag.req", 7'h00, 7'b0111111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= 3; k++) begin
            set_idle();
            bus.dmss_idle = (k == 3);
            check_outs("stag.drain", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        set_idle();
        check_outs("stag.flush0", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_idle();
        bus.dmss_flush_ack = 1'b1;
        check_outs("stag.dack", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_idle();
        check_outs("stag.ddrop", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_idle();
        bus.imss_flush_ack = 1'b1;
        check_outs("stag.iack", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        set_idle();
        check_outs("stag.resume", 7'h00, 7'h7f, 1'b1, 32'h8000_0204, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        set_idle();
        check_outs("stag.run", 7'h00, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // minimum-length fence, both acks in the first FLUSH cycle
        fence_to_flush("min", 32'h8000_0abc);
        bus.imss_flush_ack = 1'b1;
        bus.dmss_flush_ack = 1'b1;
        check_outs("min.flush", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        set_idle();
        check_outs("min.resume", 7'h00, 7'h7f, 1'b1, 32'h8000_0abc, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        set_idle();
        check_outs("min.run", 7'h00, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // fence and W redirect together: redirect wins, no fence
        set_idle();
        bus.fence_req          = 1'b1;
        bus.fence_next_pc      = 32'h9000_0000;
        bus.redirect_valid     = 1'b1;
        bus.redirect_stage_idx = 3'd6;
        bus.redirect_pc        = 32'h0000_0040;
        check_outs("coll", 7'h00, 7'b0111111, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        set_idle();
        check_outs("coll.after", 7'h00, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("coll.after2", 7'h00, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // reset while both flush requests are high
        fence_to_flush("rstf", 32'h8000_0300);
        check_outs("rstf.flush", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        check_outs("rstf.in_rst", 7'h00, 7'h7f, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check_outs("rstf.next", 7'h00, 7'h7f, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_outs("rstf.run", 7'h00, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // a latched imss ack must not survive a reset into the next fence
        fence_to_flush("latch", 32'h8000_0400);
        bus.imss_flush_ack = 1'b1;
        tick();
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        fence_to_flush("latch2", 32'h8000_0500);
        bus.dmss_flush_ack = 1'b1;
        tick();
        set_idle();
        check_outs("latch2.wait", 7'h7f, 7'h7f, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.imss_flush_ack = 1'b1;
        tick();
        set_idle();
        check_outs("latch2.resume", 7'h00, 7'h7f, 1'b1, 32'h8000_0500, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();

        // random traffic against the reference model
        m_drain = 0; m_flush = 0; m_resume = 0; m_ireq = 0; m_dreq = 0; m_pc = '0;
        for (int c = 0; c < 600; c++) begin
            m_run = !(m_drain || m_flush || m_resume);
            set_idle();
            rst_n = ($urandom_range(0, 79) != 0);
            if (m_run) begin
                for (int i = 0; i < N; i++) bus.stage_ready[i] = ($urandom_range(0, 5) != 0);
                bus.redirect_valid     = ($urandom_range(0, 2) == 0);
                bus.redirect_stage_idx = 3'($urandom_range(0, 6));
                bus.redirect_pc        = $urandom;
                bus.fence_req          = ($urandom_range(0, 7) == 0);
                bus.fence_next_pc      = $urandom;
            end else begin
                bus.stage_ready = 7'($urandom);
            end
            bus.dmss_idle      = ($urandom_range(0, 1) == 1);
            bus.imss_flush_ack = ($urandom_range(0, 3) == 0);
            bus.dmss_flush_ack = ($urandom_range(0, 3) == 0);

            e_stall = '0; e_flush = '0; e_en = 0; e_val = '0; chk_val = 0;
            e_ireq = 0; e_dreq = 0; e_busy = 0; take_r = 0; take_f = 0;
            if (!rst_n) begin
                e_flush = '1;
                chk_val = 1;
            end else if (m_run) begin
                for (int i = 0; i < N; i++)
                    for (int j = i; j < N; j++)
                        if (!bus.stage_ready[j]) e_stall[i] = 1'b1;
                idx      = int'(bus.redirect_stage_idx);
                fence_ok = bus.fence_req && !e_stall[6];
                take_r   = bus.redirect_valid && !e_stall[idx] && (idx == 6 || !fence_ok);
                take_f   = fence_ok && !take_r;
                if (take_r) begin
                    for (int i = 0; i < idx; i++) e_flush[i] = 1'b1;
                    e_en    = 1;
                    e_val   = bus.redirect_pc;
                    chk_val = 1;
                end
                if (take_f) e_flush = 7'b0111111;
                e_stall = e_stall & ~e_flush;
            end else if (m_resume) begin
                e_flush = '1; e_en = 1; e_val = m_pc; chk_val = 1; e_busy = 1;
            end else begin
                e_stall = '1; e_flush = '1; e_busy = 1;
                e_ireq  = m_flush & m_ireq;
                e_dreq  = m_flush & m_dreq;
            end

            if (e_en) exp_q.push_back(e_val);
            check_outs("rnd", e_stall, e_flush, e_en, e_val, chk_val, e_ireq, e_dreq, e_busy);
            if (bus.pc_load_en === 1'b1) begin
                if (exp_q.size() == 0) check("sb.unexpected_load", 32'h1, 32'h0);
                else check("sb.pc", bus.pc_load_val, exp_q.pop_front());
            end

            if (!rst_n) begin
                m_drain = 0; m_flush = 0; m_resume = 0; m_ireq = 0; m_dreq = 0;
            end else if (m_run) begin
                if (take_f) begin
                    m_drain = 1;
                    m_pc    = bus.fence_next_pc;
                end
            end else if (m_drain) begin
                if (bus.dmss_idle) begin
                    m_drain = 0; m_flush = 1; m_ireq = 1; m_dreq = 1;
                end
            end else if (m_flush) begin
                if (bus.imss_flush_ack) m_ireq = 0;
                if (bus.dmss_flush_ack) m_dreq = 0;
                if (!m_ireq && !m_dreq) begin
                    m_flush  = 0;
                    m_resume = 1;
                end
            end else begin
                m_resume = 0;
            end
            tick();
        end
        check("sb.leftover", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/letc_core_pipe_ctrl.md
# letc_core_pipe_ctrl

Pipeline sequencing controller for the seven-stage LETC Core (F1, F2, D, E, M1, M2, W). It turns per-stage `stage_ready` backpressure into `stage_stall`/`stage_flush` vectors and arbitrates PC redirects from branches and traps onto the fetch `pc_load_en`/`pc_load_val` port. It also runs the multi-cycle fence sequence (fence.i / sfence.vma): drain, IMSS/DMSS cache+TLB flush handshake, then resume. It sits in `letc_core_top` beside the stage instances and drives the existing `stage_stall`, `stage_flush`, `pc_load_en` and `pc_load_val` nets.

## Interface
- `NUM_STAGES`, 7, pipeline depth; stage index 0 = F1 … 6 = W (`*_STAGE_IDX` from `letc_core_pkg`).
- `clk` in 1: core clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `stage_ready` in NUM_STAGES: stage i can hand off its output this cycle.
- `redirect_valid` in 1: branch-taken or trap redirect request.
- `redirect_stage_idx` in 3: index of the requesting stage (E for branches, W for traps).
- `redirect_pc` in 32 (`pc_t`): redirect target.
- `fence_req` in 1: fence committing in W this cycle; single-cycle pulse.
- `fence_next_pc` in 32: PC of the fence + 4.
- `dmss_idle` in 1: no outstanding DMSS stores or loads.
- `imss_flush_ack` in 1: IMSS flush complete; single-cycle pulse.
- `dmss_flush_ack` in 1: DMSS flush complete; single-cycle pulse.
- `stage_stall` out NUM_STAGES: stage i holds its output register.
- `stage_flush` out NUM_STAGES: stage i invalidates its output register.
- `pc_load_en` out 1: load `pc_load_val` into F1.
- `pc_load_val` out 32: next PC.
- `imss_flush_req` out 1: level request to IMSS.
- `dmss_flush_req` out 1: level request to DMSS.
- `busy` out 1: FSM not in RUN.

## Operation
- States: RUN, DRAIN, FLUSH, RESUME. Reset → RUN.
- Backpressure in RUN: `stage_stall[i]` = OR over j≥i of `~stage_ready[j]`. This is combinational; a not-ready stage freezes itself and every younger stage.
- Redirect, RUN only:
  - Accepted when `redirect_valid` && `stage_stall[redirect_stage_idx]`==0.
  - Same cycle: `pc_load_en`=1, `pc_load_val`=`redirect_pc`, `stage_flush[i]`=1 for all i<`redirect_stage_idx`.
  - Flush overrides stall for the same stage: a flushed stage has `stage_stall` forced to 0.
  - When a redirect is not accepted, `pc_load_en`=0 and the requester holds `redirect_valid`.
- Fence:
  - `fence_req` in RUN with `stage_stall[6]`==0 → DRAIN.
  - Same cycle: `stage_flush[5:0]` = all ones. The fence itself retires normally from W.
  - Priority: `fence_req` and `redirect_valid` with `redirect_stage_idx`=6 in the same cycle → redirect wins and the fence is dropped. A redirect from a younger stage in that cycle is ignored; it is flushed anyway.
- DRAIN: `stage_stall` all ones, `stage_flush` all ones. Exit to FLUSH when `dmss_idle`=1.
- FLUSH:
  - On entry, `imss_flush_req` and `dmss_flush_req` rise together.
  - Each request drops the cycle after its own ack.
  - Acks latch in `imss_done`/`dmss_done`; the FSM moves to RESUME when both are latched.
  - Acks may arrive in the same cycle or in either order. An ack while the matching request is low is ignored.
  - Stall and flush stay all ones.
- RESUME, one cycle: `pc_load_en`=1, `pc_load_val`=`fence_next_pc` (registered at `fence_req`), `stage_flush` all ones, `stage_stall` 0 → RUN.
- `redirect_valid`, `fence_req` and `stage_ready` are ignored outside RUN. A `redirect_valid` or `fence_req` outside RUN is an assertion failure.
- No timeout: FLUSH waits indefinitely.

## Timing
- While `rst_n`=0:
  - `stage_flush` all ones, `stage_stall` 0.
  - `pc_load_en`, `imss_flush_req`, `dmss_flush_req` and `busy` are 0.
  - `pc_load_val` is 0.
- Reset mid-fence returns to RUN next cycle, with requests low and latched acks cleared.
- Redirect-to-F1 latency: 0 cycles (combinational). The target is fetched by F1 the next cycle.
- Fence minimum length:
  - `fence_req` (cycle 0) → DRAIN (1) → FLUSH (2, requests high) → acks at 2 → RESUME (3) → RUN (4).
  - `busy`=1 in cycles 1–3.
- `pc_load_val` is a don't-care when `pc_load_en`=0, except during reset.

## Test plan
- Backpressure: `stage_ready`=7'b1101111 (M1 not ready) in RUN → `stage_stall`=7'b0011111, `stage_flush`=0, `pc_load_en`=0.
- Branch: `redirect_valid`=1, `redirect_stage_idx`=3, `redirect_pc`=0x8000_0100, all ready → same cycle `pc_load_en`=1, `pc_load_val`=0x8000_0100, `stage_flush`=7'b0000111.
- Stalled redirect: same as the branch case but `stage_ready[4]`=0 → `pc_load_en`=0 and `stage_flush`=0 until ready rises; then the redirect is accepted that cycle.
- Fence, staggered acks: `fence_req`, `fence_next_pc`=0x8000_0204; `dmss_idle`=0 for 3 cycles; `dmss_flush_ack` 2 cycles before `imss_flush_ack` → `dmss_flush_req` drops first, `imss_flush_req` drops after its ack, then one RESUME cycle with `pc_load_val`=0x8000_0204, then `busy`=0.
- Collision: `fence_req` and W redirect (idx 6, pc 0x0000_0040) in the same cycle → redirect taken, FSM stays in RUN, `busy`=0, no flush requests.
- Reset during FLUSH with both requests high → next cycle both requests are 0, `busy`=0, `stage_flush` all ones while `rst_n`=0.
